hazard_ctrl_param: RTL
======================

HAZARD_CTRL_PARAM -- requirements
Module: hazard_ctrl_param

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register-specifier width.
REQ-002 SHALL have parameter LOAD_STALL, default 1, legal 1..3: load-use stall cycles.
REQ-003 SHALL have parameter FLUSH_SLOTS, default 1, legal 1..2: cycles if_flush is held per taken branch or jump.
REQ-004 SHALL have parameter BRANCH_IN_ID, default 1: 1 means beq/bne compare in ID and need branch-operand stalls; 0 disables those stalls.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port if_id_instr  input  32  instruction in ID; rs=[25:21], rt=[20:16], opcode=[31:26].
REQ-008 SHALL have port id_ex_mem_read  input  1  EX-stage instruction is a load.
REQ-009 SHALL have port id_ex_reg_write  input  1  EX-stage instruction writes a register.
REQ-010 SHALL have port id_ex_rd  input  REG_ADDR_W  EX-stage destination (after RegDst mux).
REQ-011 SHALL have port ex_mem_mem_read  input  1  MEM-stage instruction is a load.
REQ-012 SHALL have port ex_mem_rd  input  REG_ADDR_W  MEM-stage destination.
REQ-013 SHALL have port pc_src  input  2  00 seq, 01 taken branch, 10 jump, 11 treated as 00.
REQ-014 SHALL have port pc_write  output  1  PC update enable.
REQ-015 SHALL have port if_id_write  output  1  IF/ID register enable.
REQ-016 SHALL have port id_ex_bubble  output  1  selects zeroed control into ID/EX.
REQ-017 SHALL have port if_flush  output  1  zeroes IF/ID.
REQ-018 SHALL have port stall_count  output  16  saturating count of stall cycles.

Function
REQ-019 SHALL treat rt as a source only for opcodes 000000, 000100 (beq), 000101 (bne), 101011 (sw); rs always a source.
REQ-020 SHALL ignore any match against register 0.
REQ-021 SHALL compute required stall N in state RUN: load-use (id_ex_mem_read, id_ex_rd matches source) -> LOAD_STALL; if BRANCH_IN_ID and ID is beq/bne: id_ex_mem_read match -> LOAD_STALL+1, id_ex_reg_write match (non-load) -> 1, ex_mem_mem_read and ex_mem_rd match -> 1; maximum applies; else N=0.
REQ-022 SHALL implement FSM states RUN, STALL, FLUSH.
REQ-023 SHALL, in RUN with N>0, drive pc_write=0, if_id_write=0, id_ex_bubble=1, if_flush=0 combinationally in that cycle; load counter with N-1; go to STALL if N>1, else stay RUN.
REQ-024 SHALL, in STALL, hold the stall outputs, ignore all hazard inputs and pc_src, decrement the counter each cycle, and return to RUN in the cycle after the counter reads 1.
REQ-025 SHALL, in RUN with N=0 and pc_src 01 or 10, drive if_flush=1 that cycle and enter FLUSH when FLUSH_SLOTS=2.
REQ-026 SHALL, in FLUSH, drive if_flush=1 for exactly one cycle with pc_write=1, then return to RUN; new hazards in that cycle are evaluated in the next RUN cycle.
REQ-027 SHALL give stall priority over flush in the same cycle; the branch is re-evaluated once the stall ends.
REQ-028 SHALL, in RUN with N=0 and no flush, drive pc_write=1, if_id_write=1, id_ex_bubble=0, if_flush=0.
REQ-029 SHALL increment stall_count on each clock edge where pc_write=0, saturating at 0xFFFF.

Reset
REQ-030 SHALL, while rst=1, force state RUN, counter 0, stall_count 0, pc_write=1, if_id_write=1, id_ex_bubble=0, if_flush=0, independent of clk.
REQ-031 SHALL abort any STALL or FLUSH immediately on rst assertion; first post-reset cycle evaluates hazards fresh.

Verification
REQ-032 Load-use: id_ex_mem_read=1, id_ex_rd=8, instr add rs=8 (LOAD_STALL=1) -> one cycle pc_write=0, id_ex_bubble=1; stall_count=1.
REQ-033 Load then beq rs=9, id_ex_rd=9, LOAD_STALL=2 -> 3 consecutive stall cycles with inputs cleared after cycle 1; stall_count=3.
REQ-034 Register-0 load: id_ex_mem_read=1, id_ex_rd=0, instr rs=0 -> no stall, pc_write=1.
REQ-035 Taken beq, no hazard, pc_src=01, FLUSH_SLOTS=2 -> if_flush=1 for exactly 2 cycles, pc_write=1 throughout.
REQ-036 Stall plus pc_src=01 same cycle -> stall outputs, if_flush=0; rst pulse mid-STALL (LOAD_STALL=3) -> outputs at reset values before next clk edge, stall_count=0.

Source files
------------

// File: rtl/hazard_ctrl_param.sv
// Pipeline hazard controller for a 5-stage MIPS-style core: load-use and
// ID-stage branch-operand stalls, IF/ID flush on taken branches and jumps.
// Latency: outputs are combinational from the FSM state and the current
// hazard inputs. Backpressure: pc_write/if_id_write low freeze IF and ID.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   if_id_instr         - instruction sitting in ID (opcode/rs/rt decoded here)
//   id_ex_mem_read      - EX-stage instruction is a load
//   id_ex_reg_write     - EX-stage instruction writes a register
//   id_ex_rd            - EX-stage destination register
//   ex_mem_mem_read     - MEM-stage instruction is a load
//   ex_mem_rd           - MEM-stage destination register
//   pc_src              - 00 sequential, 01 taken branch, 10 jump, 11 = 00
//   pc_write            - PC update enable
//   if_id_write         - IF/ID register enable
//   id_ex_bubble        - inject zeroed control into ID/EX
//   if_flush            - zero the IF/ID register
//   stall_count         - saturating count of cycles with pc_write low
module hazard_ctrl_param #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_SLOTS  = 1,
  parameter int BRANCH_IN_ID = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           if_id_instr,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_reg_write,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [1:0]            pc_src,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_flush,
  output logic [15:0]           stall_count
);

  // Register specifiers in the instruction are 5 bits; destinations are
  // REG_ADDR_W bits. Compare both at the wider of the two widths so that
  // neither side is silently truncated.
  localparam int CMP_W = (REG_ADDR_W > 5) ? REG_ADDR_W : 5;

  // Stall lengths. LOAD_STALL is at most 3, so 3 bits cover LOAD_STALL+1.
  localparam logic [2:0] LS_N  = 3'(LOAD_STALL);
  localparam logic [2:0] LS_BR = 3'(LOAD_STALL + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------
  // Decode of the ID-stage instruction
  // ---------------------------------------------------------------------
  logic [5:0]       opcode;
  logic [CMP_W-1:0] rs, rt, ex_rd, mem_rd;
  logic             is_branch;
  logic             rt_used;
  logic             ex_hit;
  logic             mem_hit;
  logic             take_branch;

  // Immediate/funct bits are never looked at by the hazard logic.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, if_id_instr[15:0]};

  assign opcode = if_id_instr[31:26];
  assign rs     = CMP_W'(if_id_instr[25:21]);
  assign rt     = CMP_W'(if_id_instr[20:16]);
  assign ex_rd  = CMP_W'(id_ex_rd);
  assign mem_rd = CMP_W'(ex_mem_rd);

  // beq / bne are the only instructions that compare operands in ID.
  assign is_branch = (opcode == 6'b000100) || (opcode == 6'b000101);

  // rt is a real source only for R-type, beq/bne and sw; for loads and
  // immediates it is the destination and must not trigger a stall.
  assign rt_used = (opcode == 6'b000000) || is_branch || (opcode == 6'b101011);

  // Register 0 is hard-wired to zero, so a "dependency" on it is never real.
  assign ex_hit  = (ex_rd != '0)  && ((ex_rd == rs)  || (rt_used && (ex_rd == rt)));
  assign mem_hit = (mem_rd != '0) && ((mem_rd == rs) || (rt_used && (mem_rd == rt)));

  // pc_src 11 is reserved and behaves as sequential fetch.
  assign take_branch = (pc_src == 2'b01) || (pc_src == 2'b10);

  // ---------------------------------------------------------------------
  // Required stall length for the instruction in ID (largest rule wins)
  // ---------------------------------------------------------------------
  logic [2:0] need_n;

  always_comb begin
    need_n = 3'd0;
    // Classic load-use: the loaded value is only available after MEM.
    if (id_ex_mem_read && ex_hit) begin
      need_n = LS_N;
    end
    if ((BRANCH_IN_ID != 0) && is_branch) begin
      // Branch compares in ID need the load value one stage earlier still.
      if (id_ex_mem_read && ex_hit && (LS_BR > need_n)) begin
        need_n = LS_BR;
      end
      // ALU result in EX cannot be forwarded back into the ID comparator.
      if (!id_ex_mem_read && id_ex_reg_write && ex_hit && (need_n < 3'd1)) begin
        need_n = 3'd1;
      end
      // Load in MEM: its data arrives at the end of this cycle.
      if (ex_mem_mem_read && mem_hit && (need_n < 3'd1)) begin
        need_n = 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_flush     = 1'b0;

    unique case (state_q)
      RUN: begin
        cnt_d = 3'd0;
        if (need_n != 3'd0) begin
          // A stall wins over a simultaneous redirect; the branch is still
          // sitting in ID and gets re-evaluated once the stall ends.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_d        = need_n - 3'd1;
          if (need_n > 3'd1) begin
            state_d = STALL;
          end
        end else if (take_branch) begin
          if_flush = 1'b1;
          if (FLUSH_SLOTS >= 2) begin
            state_d = FLUSH;
          end
        end
      end

      STALL: begin
        // Hazard inputs are not re-examined here: the stall length was
        // fixed when the hazard was first seen.
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        cnt_d        = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
        end
      end

      FLUSH: begin
        // Second wrong-path slot; anything now in ID is judged next cycle.
        if_flush = 1'b1;
        state_d  = RUN;
      end

      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase

    // Reset must show idle outputs immediately, even while hazard inputs
    // would otherwise request a stall in RUN.
    if (rst) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_flush     = 1'b0;
    end
  end

  // Stall cycle counter, saturating so it never wraps back to a small value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule
